muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit_divu_core.sv | 48 ++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - RV32M funct3 encodings, FSM states and XLEN for the mul/div unit
package muldiv_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      DIV_RUN,
      DONE
   } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue and writeback signals between the core and the mul/div unit
interface muldiv_unit_if
   import muldiv_unit_pkg::*;
#(
   parameter int n = XLEN
);
   logic         start;
   logic         kill;
   logic [2:0]   funct3;
   logic [n-1:0] op_a;
   logic [n-1:0] op_b;
   logic [4:0]   rd_in;
   logic         busy;
   logic         done;
   logic [n-1:0] result;
   logic [4:0]   rd_out;
   logic         wb_en;

   modport master (
      output start, kill, funct3, op_a, op_b, rd_in,
      input  busy, done, result, rd_out, wb_en
   );

   modport slave (
      input  start, kill, funct3, op_a, op_b, rd_in,
      output busy, done, result, rd_out, wb_en
   );
endinterface

// File: rtl/muldiv_unit_divu_core.sv
// rtl/muldiv_unit_divu_core.sv - n-step unsigned restoring divider; exposes the post-step values
module divu_core #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [n-1:0] dividend_i,
   input  logic [n-1:0] divisor_i,
   output logic [n-1:0] q_next_o,
   output logic [n-1:0] r_next_o,
   output logic         last_o
);
   localparam int CW = $clog2(n);
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   logic [n-1:0]  quo_q, rem_q, dvs_q;
   logic [CW-1:0] cnt_q;
   logic [n:0]    shifted, diff;
   logic          fits;

   // Partial remainder stays below the divisor, so a non-negative difference always fits in n bits.
   assign shifted  = {rem_q, quo_q[n-1]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign fits     = ~diff[n];
   assign q_next_o = {quo_q[n-2:0], fits};
   assign r_next_o = fits ? diff[n-1:0] : shifted[n-1:0];
   assign last_o   = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
         cnt_q <= '0;
      end else if (en_i) begin
         quo_q <= q_next_o;
         rem_q <= r_next_o;
         cnt_q <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit: FSM, sign handling, shift-add multiplier
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int n = XLEN
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(n);
   localparam logic [CW-1:0] LAST    = CW'(n - 1);
   localparam logic [n-1:0]  MIN_NEG = {1'b1, {(n-1){1'b0}}};

   state_e          state_q, state_d;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q, rd_out_q;
   logic [n-1:0]    a_q, b_q, mcand_q, result_q;
   logic [2*n-1:0]  prod_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, rneg_q, spec_q;

   logic            accept, a_sgn, b_sgn, spec_in;
   logic [n-1:0]    a_mag, b_mag;
   logic [n:0]      mul_sum;
   logic [2*n-1:0]  prod_step, prod_sgn;
   logic [n-1:0]    q_next, r_next, quo_sgn, rem_sgn;
   logic            div_last;
   logic            res_ld;
   logic [n-1:0]    res_val;

   assign accept  = (state_q == IDLE) && bus.start && !bus.kill;
   assign a_sgn   = bus.op_a[n-1] && (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU ||
                                      bus.funct3 == F3_DIV  || bus.funct3 == F3_REM);
   assign b_sgn   = bus.op_b[n-1] && (bus.funct3 == F3_MULH || bus.funct3 == F3_DIV ||
                                      bus.funct3 == F3_REM);
   assign a_mag   = a_sgn ? -bus.op_a : bus.op_a;
   assign b_mag   = b_sgn ? -bus.op_b : bus.op_b;
   assign spec_in = bus.funct3[2] && ((bus.op_b == '0) ||
                    (!bus.funct3[0] && bus.op_a == MIN_NEG && (&bus.op_b)));

   // Multiplier bits shift out of the low half as the partial product shifts in from the top.
   assign mul_sum   = {1'b0, prod_q[2*n-1:n]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign prod_step = {mul_sum, prod_q[n-1:1]};
   assign prod_sgn  = neg_q ? -prod_step : prod_step;
   assign quo_sgn   = neg_q ? -q_next : q_next;
   assign rem_sgn   = rneg_q ? -r_next : r_next;

   divu_core #(.n(n)) u_divu (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept),
      .en_i       (state_q == DIV_RUN),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .q_next_o   (q_next),
      .r_next_o   (r_next),
      .last_o     (div_last)
   );

   always_comb begin
      state_d = state_q;
      res_ld  = 1'b0;
      res_val = '0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = bus.funct3[2] ? DIV_RUN : MUL_RUN;
         end
         MUL_RUN: begin
            if (cnt_q == LAST) begin
               state_d = DONE;
               res_ld  = 1'b1;
               res_val = (f3_q == F3_MUL) ? prod_sgn[n-1:0] : prod_sgn[2*n-1:n];
            end
         end
         DIV_RUN: begin
            if (spec_q) begin
               state_d = DONE;
               res_ld  = 1'b1;
               if (b_q == '0) res_val = f3_q[1] ? a_q : '1;
               else           res_val = f3_q[1] ? '0  : a_q;
            end else if (div_last) begin
               state_d = DONE;
               res_ld  = 1'b1;
               res_val = f3_q[1] ? rem_sgn : quo_sgn;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.kill) begin
         state_d = IDLE;
         res_ld  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         f3_q     <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         spec_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            f3_q    <= bus.funct3;
            rd_q    <= bus.rd_in;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            mcand_q <= a_mag;
            prod_q  <= {{n{1'b0}}, b_mag};
            cnt_q   <= '0;
            neg_q   <= a_sgn ^ b_sgn;
            rneg_q  <= a_sgn;
            spec_q  <= spec_in;
         end else if (state_q == MUL_RUN) begin
            prod_q  <= prod_step;
            cnt_q   <= cnt_q + CW'(1);
         end
         if (res_ld) begin
            result_q <= res_val;
            rd_out_q <= rd_q;
         end
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
   assign bus.wb_en  = (state_q == DONE) && (rd_out_q != 5'd0);
endmodule
